// File: rtl/r2sdf_stage_p_if.sv
// Sample, twiddle and result bundle for one radix-2 single-path delay-feedback FFT stage.
interface r2sdf_stage_p_if #(
  parameter int DW  = 16,
  parameter int TWW = 3,
  parameter int OW  = 17
);
  logic                  valid_i;
  logic                  sof_i;
  logic signed [DW-1:0]  data_in_r;
  logic signed [DW-1:0]  data_in_i;
  logic signed [15:0]    tw_r;
  logic signed [15:0]    tw_i;
  logic [TWW-1:0]        tw_idx;
  logic                  valid_o;
  logic signed [OW-1:0]  data_out_r;
  logic signed [OW-1:0]  data_out_i;

  modport master (
    output valid_i, sof_i, data_in_r, data_in_i, tw_r, tw_i,
    input  tw_idx, valid_o, data_out_r, data_out_i
  );

  modport slave (
    input  valid_i, sof_i, data_in_r, data_in_i, tw_r, tw_i,
    output tw_idx, valid_o, data_out_r, data_out_i
  );
endinterface

// File: rtl/r2sdf_stage_p.sv
// Radix-2 single-path delay-feedback FFT stage: prime / butterfly / drain over a
// DEPTH-long feedback delay line, optional twiddle multiply and output halving.
module r2sdf_stage_p #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int TW_EN = 1,
  parameter int SCALE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  r2sdf_stage_p_if.slave bus
);
  localparam int OW  = DW + 1 - SCALE;
  localparam int TWW = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 1;
  localparam int L   = 2 * DEPTH;
  localparam int CW  = $clog2(L);
  localparam int EW  = DW + 1;
  localparam int PW  = DW + 18;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(32'd1);

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    BFLY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  logic                 v_r, sof_r;
  logic signed [DW-1:0] x_re_r, x_im_r;
  state_e               state_r, state_nxt_s, op_s;
  logic [CW-1:0]        cnt_r, idx_s, idx_nxt_s;
  logic signed [EW-1:0] dl_re_r [DEPTH];
  logic signed [EW-1:0] dl_im_r [DEPTH];
  logic signed [EW-1:0] x_re_s, x_im_s, head_re_s, head_im_s;
  logic signed [EW-1:0] push_re_s, push_im_s, res_re_s, res_im_s;
  logic [TWW-1:0]       tw_idx_s, tw_idx_r;
  logic                 s1_valid_r, s1_tw_r;
  logic signed [EW-1:0] s1_re_r, s1_im_r;
  logic signed [PW-1:0] mul_re_s, mul_im_s;
  logic signed [EW-1:0] fin_re_s, fin_im_s;
  logic                 valid_o_r;
  logic signed [OW-1:0] out_re_r, out_im_r;

  // Q1.14 product sum: round half up, then clamp to the DW+1 datapath
  function automatic logic signed [EW-1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    logic signed [PW-1:0] s;
    logic signed [EW-1:0] r;
    t = p + {{(PW-14){1'b0}}, 14'd8192};
    s = t >>> 5'd14;
    if ((&s[PW-1:DW]) || (~|s[PW-1:DW])) begin
      r = s[DW:0];
    end else begin
      r = s[PW-1] ? {1'b1, {DW{1'b0}}} : {1'b0, {DW{1'b1}}};
    end
    return r;
  endfunction

  // Optional halving with rounding, clamped to the narrower output width
  function automatic logic signed [OW-1:0] scale_out(input logic signed [EW-1:0] v);
    logic signed [EW:0]   t;
    logic signed [EW:0]   h;
    logic signed [OW-1:0] r;
    t = {v[DW], v} + {{EW{1'b0}}, 1'b1};
    h = t >>> 1'b1;
    if (SCALE == 32'sd0) begin
      r = v[OW-1:0];
    end else if ((&h[EW:DW-1]) || (~|h[EW:DW-1])) begin
      r = h[OW-1:0];
    end else begin
      r = h[EW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
    return r;
  endfunction

  // Input capture: all processing works from the registered sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r    <= 1'b0;
      sof_r  <= 1'b0;
      x_re_r <= {DW{1'b0}};
      x_im_r <= {DW{1'b0}};
    end else begin
      v_r   <= bus.valid_i;
      sof_r <= bus.valid_i & bus.sof_i;
      if (bus.valid_i) begin
        x_re_r <= bus.data_in_r;
        x_im_r <= bus.data_in_i;
      end
    end
  end

  // Phase register; a start-of-frame sample always restarts priming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= PRIME;
    end else if (v_r) begin
      state_r <= state_nxt_s;
    end
  end

  // Per-sample operation, delay-line write value and next phase
  always_comb begin
    x_re_s      = {x_re_r[DW-1], x_re_r};
    x_im_s      = {x_im_r[DW-1], x_im_r};
    head_re_s   = dl_re_r[DEPTH-1];
    head_im_s   = dl_im_r[DEPTH-1];
    idx_s       = sof_r ? {CW{1'b0}} : cnt_r;
    idx_nxt_s   = idx_s + ONE_C;
    op_s        = sof_r ? PRIME : state_r;
    push_re_s   = x_re_s;
    push_im_s   = x_im_s;
    res_re_s    = {EW{1'b0}};
    res_im_s    = {EW{1'b0}};
    tw_idx_s    = {TWW{1'b0}};
    state_nxt_s = op_s;
    case (op_s)
      PRIME: begin
        push_re_s = x_re_s;
        push_im_s = x_im_s;
      end
      BFLY: begin
        push_re_s = head_re_s - x_re_s;
        push_im_s = head_im_s - x_im_s;
        res_re_s  = head_re_s + x_re_s;
        res_im_s  = head_im_s + x_im_s;
      end
      DRAIN: begin
        res_re_s = head_re_s;
        res_im_s = head_im_s;
        tw_idx_s = (DEPTH > 32'sd1) ? idx_s[TWW-1:0] : {TWW{1'b0}};
      end
      default: begin
        push_re_s = x_re_s;
        push_im_s = x_im_s;
      end
    endcase
    if (idx_nxt_s == DEPTH_C) begin
      state_nxt_s = BFLY;
    end else if ((idx_nxt_s == {CW{1'b0}}) && (op_s == BFLY)) begin
      state_nxt_s = DRAIN;
    end else begin
      state_nxt_s = op_s;
    end
  end

  // Counter, delay line and first pipeline stage advance only on accepted samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CW{1'b0}};
      s1_valid_r <= 1'b0;
      s1_tw_r    <= 1'b0;
      s1_re_r    <= {EW{1'b0}};
      s1_im_r    <= {EW{1'b0}};
      tw_idx_r   <= {TWW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        dl_re_r[i] <= {EW{1'b0}};
        dl_im_r[i] <= {EW{1'b0}};
      end
    end else if (v_r) begin
      cnt_r      <= idx_nxt_s;
      s1_valid_r <= (op_s != PRIME);
      s1_tw_r    <= (op_s == DRAIN) && (TW_EN == 32'sd1);
      s1_re_r    <= res_re_s;
      s1_im_r    <= res_im_s;
      tw_idx_r   <= tw_idx_s;
      dl_re_r[0] <= push_re_s;
      dl_im_r[0] <= push_im_s;
      for (int i = 1; i < DEPTH; i++) begin
        dl_re_r[i] <= dl_re_r[i-1];
        dl_im_r[i] <= dl_im_r[i-1];
      end
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // Twiddle ROM answers tw_idx_r combinationally during the second stage
  always_comb begin
    mul_re_s = PW'(s1_re_r) * PW'(bus.tw_r) - PW'(s1_im_r) * PW'(bus.tw_i);
    mul_im_s = PW'(s1_re_r) * PW'(bus.tw_i) + PW'(s1_im_r) * PW'(bus.tw_r);
    if (s1_tw_r) begin
      fin_re_s = round_sat(mul_re_s);
      fin_im_s = round_sat(mul_im_s);
    end else begin
      fin_re_s = s1_re_r;
      fin_im_s = s1_im_r;
    end
  end

  // Output register; data holds between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o_r <= 1'b0;
      out_re_r  <= {OW{1'b0}};
      out_im_r  <= {OW{1'b0}};
    end else begin
      valid_o_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_re_r <= scale_out(fin_re_s);
        out_im_r <= scale_out(fin_im_s);
      end
    end
  end

  assign bus.tw_idx     = tw_idx_r;
  assign bus.valid_o    = valid_o_r;
  assign bus.data_out_r = out_re_r;
  assign bus.data_out_i = out_im_r;
endmodule

// File: tb/tb_r2sdf_stage_p.sv
// Self-checking bench: three stage variants (plain, twiddled, halved) on shared stimulus
// against a queue-based frame model.
module tb_r2sdf_stage_p;
  localparam int DEPTH = 4;
  localparam int L     = 2 * DEPTH;

  typedef struct {
    longint due;
    longint re;
    longint im;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               drv_v   = 1'b0;
  logic               drv_sof = 1'b0;
  logic signed [15:0] drv_re  = 16'sd0;
  logic signed [15:0] drv_im  = 16'sd0;
  logic signed [15:0] tw_tab_r [DEPTH];
  logic signed [15:0] tw_tab_i [DEPTH];

  r2sdf_stage_p_if #(.DW(16), .TWW(2), .OW(17)) if_a ();
  r2sdf_stage_p_if #(.DW(16), .TWW(2), .OW(17)) if_b ();
  r2sdf_stage_p_if #(.DW(16), .TWW(2), .OW(16)) if_c ();

  assign if_a.valid_i = drv_v;    assign if_b.valid_i = drv_v;    assign if_c.valid_i = drv_v;
  assign if_a.sof_i = drv_sof;    assign if_b.sof_i = drv_sof;    assign if_c.sof_i = drv_sof;
  assign if_a.data_in_r = drv_re; assign if_b.data_in_r = drv_re; assign if_c.data_in_r = drv_re;
  assign if_a.data_in_i = drv_im; assign if_b.data_in_i = drv_im; assign if_c.data_in_i = drv_im;
  assign if_a.tw_r = tw_tab_r[if_a.tw_idx]; assign if_a.tw_i = tw_tab_i[if_a.tw_idx];
  assign if_b.tw_r = tw_tab_r[if_b.tw_idx]; assign if_b.tw_i = tw_tab_i[if_b.tw_idx];
  assign if_c.tw_r = tw_tab_r[if_c.tw_idx]; assign if_c.tw_i = tw_tab_i[if_c.tw_idx];

  r2sdf_stage_p #(.DW(16), .DEPTH(DEPTH), .TW_EN(0), .SCALE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  r2sdf_stage_p #(.DW(16), .DEPTH(DEPTH), .TW_EN(1), .SCALE(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  r2sdf_stage_p #(.DW(16), .DEPTH(DEPTH), .TW_EN(0), .SCALE(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic   obs_v  [3];
  longint obs_re [3];
  longint obs_im [3];
  assign obs_v[0] = if_a.valid_o; assign obs_re[0] = longint'(if_a.data_out_r); assign obs_im[0] = longint'(if_a.data_out_i);
  assign obs_v[1] = if_b.valid_o; assign obs_re[1] = longint'(if_b.data_out_r); assign obs_im[1] = longint'(if_b.data_out_i);
  assign obs_v[2] = if_c.valid_o; assign obs_re[2] = longint'(if_c.data_out_r); assign obs_im[2] = longint'(if_c.data_out_i);

  int     n_err, n_chk, cyc_n;
  int     nv [3];
  longint m_re [$];
  longint m_im [$];
  int     m_idx;
  bit     m_drain;
  exp_t   expq [3][$];
  longint twq_due [$];
  longint twq_val [$];
  longint rec_re [3][$];
  longint rec_im [3][$];
  longint sum_exp [8] = '{4, 6, 8, 10, -4, -4, -4, -4};

  function automatic longint sat(input longint v, input int bits);
    longint hi, lo;
    hi = (longint'(1) << (bits - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic longint rnd14(input longint p);
    return sat((p + 8192) >>> 14, 17);
  endfunction

  function automatic longint halve(input longint v);
    return sat((v + 1) >>> 1, 16);
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Frame model: first half queued, second half butterflied, differences drained next frame
  task automatic model(input longint xr, input longint xi, input bit sof);
    longint ar, ai, wr, wi;
    exp_t   e;
    if (sof) begin
      m_idx = 0; m_drain = 0; m_re.delete(); m_im.delete();
    end
    e.due = cyc_n + 2;
    if (m_idx >= DEPTH) begin
      ar = m_re.pop_front(); ai = m_im.pop_front();
      m_re.push_back(ar - xr); m_im.push_back(ai - xi);
      e.re = ar + xr; e.im = ai + xi;
      expq[0].push_back(e); expq[1].push_back(e);
      e.re = halve(ar + xr); e.im = halve(ai + xi);
      expq[2].push_back(e);
      if (m_idx == L - 1) m_drain = 1;
    end else if (m_drain) begin
      ar = m_re.pop_front(); ai = m_im.pop_front();
      m_re.push_back(xr); m_im.push_back(xi);
      wr = tw_tab_r[m_idx]; wi = tw_tab_i[m_idx];
      e.re = ar; e.im = ai; expq[0].push_back(e);
      e.re = rnd14(ar * wr - ai * wi); e.im = rnd14(ar * wi + ai * wr); expq[1].push_back(e);
      e.re = halve(ar); e.im = halve(ai); expq[2].push_back(e);
      twq_due.push_back(cyc_n + 1); twq_val.push_back(m_idx);
    end else begin
      m_re.push_back(xr); m_im.push_back(xi);
    end
    m_idx = (m_idx + 1) % L;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      bit   expv;
      exp_t e;
      expv = (expq[k].size() > 0) && (expq[k][0].due == cyc_n);
      chk($sformatf("valid_o[%0d]@%0d", k, cyc_n), longint'(obs_v[k]), longint'(expv));
      if (obs_v[k]) begin
        nv[k]++;
        rec_re[k].push_back(obs_re[k]);
        rec_im[k].push_back(obs_im[k]);
      end
      if (expv) begin
        e = expq[k].pop_front();
        if (obs_v[k]) begin
          chk($sformatf("out_re[%0d]@%0d", k, cyc_n), obs_re[k], e.re);
          chk($sformatf("out_im[%0d]@%0d", k, cyc_n), obs_im[k], e.im);
        end
      end
    end
    if ((twq_due.size() > 0) && (twq_due[0] == cyc_n)) begin
      chk($sformatf("tw_idx@%0d", cyc_n), longint'(if_b.tw_idx), twq_val[0]);
      void'(twq_due.pop_front());
      void'(twq_val.pop_front());
    end
  endtask

  task automatic cyc(input bit v, input bit s, input longint xr, input longint xi);
    drv_v = v; drv_sof = s; drv_re = 16'(xr); drv_im = 16'(xi);
    @(posedge clk);
    cyc_n++;
    if (v && rst_n) model(xr, xi, s);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_valid[%0d]", tag, k), longint'(obs_v[k]), 0);
      chk($sformatf("%s_re[%0d]", tag, k), obs_re[k], 0);
      chk($sformatf("%s_im[%0d]", tag, k), obs_im[k], 0);
    end
    chk({tag, "_tw_idx_a"}, longint'(if_a.tw_idx), 0);
    chk({tag, "_tw_idx_b"}, longint'(if_b.tw_idx), 0);
    chk({tag, "_tw_idx_c"}, longint'(if_c.tw_idx), 0);
  endtask

  task automatic clear_rec();
    for (int k = 0; k < 3; k++) begin
      rec_re[k].delete(); rec_im[k].delete();
    end
  endtask

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++) begin
      logic signed [15:0] rr, ri;
      rr = 16'($urandom); ri = 16'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, rr, ri);
    end
  endtask

  initial begin
    int base;
    n_err = 0; n_chk = 0; cyc_n = 0; m_idx = 0; m_drain = 0;
    for (int k = 0; k < 3; k++) nv[k] = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tw_tab_r[i] = 16'sd0; tw_tab_i[i] = -16'sd16384;
    end
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // ramp 0..7 with sof, then four zeros to drain the differences
    clear_rec();
    for (int i = 0; i < L; i++) cyc(1'b1, i == 0, i, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 0, 0);
    repeat (3) cyc(1'b0, 1'b0, 0, 0);
    chk("ramp_count_a", rec_re[0].size(), 8);
    for (int i = 0; i < 8 && i < rec_re[0].size(); i++) begin
      chk($sformatf("ramp_re_a[%0d]", i), rec_re[0][i], sum_exp[i]);
      chk($sformatf("ramp_im_a[%0d]", i), rec_im[0][i], 0);
    end
    for (int i = 4; i < 8 && i < rec_re[1].size(); i++) begin
      chk($sformatf("ramp_re_b[%0d]", i), rec_re[1][i], 0);
      chk($sformatf("ramp_im_b[%0d]", i), rec_im[1][i], 4);
    end

    // full-scale sums through the halving variant
    clear_rec();
    cyc(1'b1, 1'b1, 32767, 0);  repeat (3) cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 32767, 0);  repeat (3) cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, -32768, 0); repeat (3) cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, -32768, 0); repeat (3) cyc(1'b1, 1'b0, 0, 0);
    repeat (3) cyc(1'b0, 1'b0, 0, 0);
    chk("scale_count_c", rec_re[2].size(), 8);
    if (rec_re[2].size() >= 5) begin
      chk("scale_pos_c", rec_re[2][0], 32767);
      chk("scale_neg_c", rec_re[2][4], -32768);
      chk("scale_pos_a", rec_re[0][0], 65534);
      chk("scale_neg_a", rec_re[0][4], -65536);
    end

    // sof landing on index 6 of a draining frame
    clear_rec();
    base = nv[0];
    for (int i = 0; i < L; i++) cyc(1'b1, i == 0, i + 1, -i);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 50 + i, i);
    cyc(1'b1, 1'b1, 100, 0);
    for (int i = 1; i < DEPTH; i++) cyc(1'b1, 1'b0, 100 + i, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 200 + i, 0);
    repeat (3) cyc(1'b0, 1'b0, 0, 0);
    chk("midsof_count_a", nv[0] - base, 14);
    for (int i = 0; i < 4 && rec_re[0].size() == 14; i++)
      chk($sformatf("midsof_re_a[%0d]", i), rec_re[0][10 + i], 300 + 2 * i);

    // ramp again with random idle gaps between samples
    clear_rec();
    base = nv[0];
    for (int i = 0; i < L + DEPTH; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 0, 0);
      cyc(1'b1, i == 0, (i < L) ? i : 0, 0);
    end
    repeat (3) cyc(1'b0, 1'b0, 0, 0);
    chk("gap_count_a", nv[0] - base, 8);
    for (int i = 0; i < 8 && i < rec_re[0].size(); i++)
      chk($sformatf("gap_re_a[%0d]", i), rec_re[0][i], sum_exp[i]);

    // random data and twiddles, with an asynchronous reset mid-stream
    for (int i = 0; i < DEPTH; i++) begin
      tw_tab_r[i] = 16'($urandom); tw_tab_i[i] = 16'($urandom);
    end
    rand_run(300);
    drv_v = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    m_idx = 0; m_drain = 0; m_re.delete(); m_im.delete();
    for (int k = 0; k < 3; k++) expq[k].delete();
    twq_due.delete(); twq_val.delete();
    @(posedge clk); cyc_n++;
    @(negedge clk);
    chk_zero("in_rst");
    rst_n = 1'b1;
    base = nv[0];
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1000 + i, i);
    repeat (2) cyc(1'b0, 1'b0, 0, 0);
    chk("post_rst_quiet", nv[0] - base, 0);
    cyc(1'b1, 1'b0, 7, 7);
    repeat (2) cyc(1'b0, 1'b0, 0, 0);
    chk("post_rst_first", nv[0] - base, 1);
    rand_run(300);
    repeat (3) cyc(1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/r2sdf_stage_p.md
R2SDF_STAGE_P -- requirements
Module: r2sdf_stage_p

Interface
REQ-001 Parameter DW, default 16: input sample width per component, two's complement, range 8..24.
REQ-002 Parameter DEPTH, default 8: feedback delay length, power of two, range 1..64; frame length L = 2*DEPTH.
REQ-003 Parameter TW_EN, default 1: 1 applies twiddle multiply to drained differences, 0 bypasses it.
REQ-004 Parameter SCALE, default 0: 1 halves outputs with rounding; output width OW = DW+1-SCALE.
REQ-005 Derived TWW = max(1, clog2(DEPTH)).
REQ-006 clk  in  1  clock; reset rst_n, asynchronous, active-low; clock clk.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 valid_i  in  1  input sample strobe.
REQ-009 sof_i  in  1  start of frame, qualified by valid_i.
REQ-010 data_in_r / data_in_i  in  DW each  signed input sample.
REQ-011 tw_r / tw_i  in  16 each  signed Q1.14 twiddle, combinational response to tw_idx.
REQ-012 tw_idx  out  TWW  twiddle ROM index.
REQ-013 valid_o  out  1  output sample strobe.
REQ-014 data_out_r / data_out_i  out  OW each  signed output sample.

Function
REQ-015 valid_i, sof_i and data_in_r/i SHALL be registered before any internal use; all processing SHALL advance only on cycles where the registered valid is 1.
REQ-016 Sample counter cnt, clog2(L) bits, SHALL increment per accepted sample, wrap L-1 -> 0, and be forced to 0 for a sample accepted with sof_i=1; that sample SHALL count as index 0.
REQ-017 FSM states: PRIME, BFLY, DRAIN. Reset and sof SHALL enter PRIME. cnt<DEPTH in PRIME or DRAIN: push sample into delay line. cnt reaches DEPTH: go to BFLY. cnt wraps to 0 from BFLY: go to DRAIN. BFLY -> DRAIN -> BFLY thereafter.
REQ-018 PRIME: sample pushed into delay line sign-extended to DW+1 bits; no output produced.
REQ-019 BFLY: with delay-line head A and registered input x, output A+x (DW+1 bits, no overflow possible) and push A-x into the delay line.
REQ-020 DRAIN: push x, output delay-line head D; when TW_EN=1 output D*(tw_r + j*tw_i), each component computed as (sum of products + 2^13) >>> 14, saturated to DW+1 bits.
REQ-021 tw_idx SHALL equal cnt[TWW-1:0] during DRAIN and 0 otherwise; when DEPTH=1 tw_idx SHALL be constant 0.
REQ-022 SCALE=1: final DW+1 result SHALL be (v+1)>>>1, saturated to DW bits.
REQ-023 Output SHALL be registered; a sample accepted at edge t SHALL produce valid_o=1 for exactly one cycle after edge t+2, in BFLY and DRAIN only.
REQ-024 Cycles with valid_i=0 SHALL leave cnt, FSM, delay line and data_out unchanged, with valid_o=0.
REQ-025 sof_i in BFLY/DRAIN SHALL discard pending delay-line contents and produce no output for that sample.
REQ-026 Consecutive sof_i samples SHALL each restart PRIME at index 0.

Reset
REQ-027 During rst_n=0, all registers SHALL clear immediately: valid_o=0, data_out_r/i=0, tw_idx=0, cnt=0, delay line=0, FSM=PRIME.
REQ-028 Reset mid-frame SHALL discard all in-flight samples; first accepted sample after release SHALL be treated as index 0.

Verification
REQ-029 Reset: assert rst_n=0 mid-stream -> all outputs 0 in same cycle; no valid_o until DEPTH+1 samples after release.
REQ-030 DW=16, DEPTH=4, TW_EN=0: continuous inputs real 0..7 with sof on 0, then 4 zeros -> outputs 4,6,8,10 then -4,-4,-4,-4, imag 0, each 2 cycles after its input.
REQ-031 TW_EN=1, tw=(0,-16384) during DRAIN, same stimulus -> drained outputs real 0, imag +4; tw_idx sequence 0,1,2,3.
REQ-032 SCALE=1: x=32767 at indices 0 and 4 -> sum output 32767; x=-32768 both -> -32768.
REQ-033 Random valid_i gaps on REQ-030 stimulus -> identical output sequence, valid_o count equal to accepted BFLY+DRAIN samples.
REQ-034 sof_i at index 6 of a frame -> no output for it; next 3 samples produce no output; butterfly resumes at the following sample.
